// File: rtl/smult_issue_ctrl.sv
// smult_issue_ctrl: issue controller for a pipelined FP16 scalar-vector
// multiplier that uses a start/done handshake.
// Holds a small vector register file and executes host commands of the form
// vreg[dst] = scalar * vreg[src] by driving the multiplier, waiting for done,
// writing the product back and tracking overflow / timeout errors.
//
// Optional build macro SMULT_OVF_SQUASH_EN: when defined, an overflowing
// product is not written back (the destination keeps its old contents);
// the overflow flag is set either way.
module smult_issue_ctrl #(
  parameter int LANES   = 16,
  parameter int NREGS   = 4,
  parameter int TIMEOUT = 15,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int VW     = 16 * LANES,
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          Clk1,
  input  logic          Reset,
  // host command interface
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   cmd_scalar,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  // host vector register access
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [VW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [VW-1:0] rd_data,
  // multiplier handshake
  output logic          mult_start,
  output logic [15:0]   mult_scalar,
  output logic [VW-1:0] mult_vec,
  input  logic [VW-1:0] mult_product,
  input  logic          mult_V,
  input  logic          mult_done,
  // status
  output logic          busy,
  output logic          ovf_sticky,
  output logic          timeout_err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] dst_reg;
  logic [VW-1:0] vreg [NREGS];

  // decoded per-cycle actions from the FSM
  logic          accept;
  logic          abort;
  logic          do_write;
  logic          cnt_inc;
  logic          wb_en;

`ifdef SMULT_OVF_SQUASH_EN
  // An overflowing product is discarded so the destination keeps its value.
  assign wb_en = do_write & ~mult_V;
`else
  assign wb_en = do_write;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rd_data   = vreg[rd_addr];

  // State register.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and action decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    do_write  = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mult_done) begin
          state_nxt = WRITE;
        end else if (wait_cnt == CNT_MAX) begin
          abort     = 1'b1;
          state_nxt = RELEASE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WRITE: begin
        do_write  = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Hold start low until the responder has dropped done, so it always
        // sees at least one low-start cycle before the next operation.
        if (!mult_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // WAIT-state cycle counter used for the timeout abort.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Multiplier request: start and operands are latched on accept and held
  // stable until the operation completes or is aborted.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      mult_start  <= 1'b0;
      mult_scalar <= '0;
      mult_vec    <= '0;
      dst_reg     <= '0;
    end else if (accept) begin
      mult_start  <= 1'b1;
      mult_scalar <= cmd_scalar;
      mult_vec    <= vreg[cmd_src];
      dst_reg     <= cmd_dst;
    end else if (abort || do_write) begin
      mult_start  <= 1'b0;
    end
  end

  // Vector register file: host writes only while idle, product writeback
  // only in WRITE, so the two can never target the file on the same edge.
  // A host write on the accept edge does not bypass into mult_vec.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        vreg[i] <= '0;
      end
    end else if ((state == IDLE) && wr_en) begin
      vreg[wr_addr] <= wr_data;
    end else if (wb_en) begin
      vreg[dst_reg] <= mult_product;
    end
  end

  // Sticky error flags: a set event takes priority over a same-cycle clear.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      ovf_sticky  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (do_write && mult_V) begin
        ovf_sticky <= 1'b1;
      end else if (err_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (abort) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
